dct_zigzag_quantizer: RTL and testbench
=======================================

// Module: dct_zigzag_quantizer
// PURPOSE
//  Downstream of the 2D-DCT controller/datapath. On start (driven from the controller's done1), reads the 64
//  coefficients of one 8x8 block from the result RAM in zig-zag order. Quantizes each coefficient against a
//  fixed reciprocal table and streams the results out over a valid/ready interface, one coefficient per beat.
// PARAMETERS
//  COEF_W   16  signed coefficient width in result RAM
//  OUT_W    12  signed quantized output width
//  RECIP_W  16  unsigned reciprocal width, Q0.16 (recip = round(65536/Q))
//  FIFO_D    4  output FIFO depth (power of 2)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  start      in   1        1-cycle pulse: block in RAM is final
//  bypass     in   1        1 = no quantization (saturate only); sampled at start
//  busy       out  1        high from cycle after start until done
//  done       out  1        1-cycle pulse when beat 63 is accepted
//  rd_en      out  1        RAM read strobe
//  rd_addr    out  6        RAM address, row*8+col (row = vertical freq)
//  rd_data    in   COEF_W   RAM data, valid exactly 1 cycle after rd_en
//  out_valid  out  1        output beat valid
//  out_ready  in   1        consumer accepts when valid&ready
//  out_data   out  OUT_W    quantized coefficient, signed
//  out_idx    out  6        zig-zag index n of beat (0..63)
//  out_last   out  1        high with beat n=63
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; FIFO empty; counters 0. Reset mid-block aborts: no done, partial beats lost.
//  FSM: IDLE -start-> FETCH; FETCH -(64th read issued)-> DRAIN; DRAIN -(beat 63 accepted)-> DONE; DONE -> IDLE.
//   done=1 only in DONE cycle. busy=1 in FETCH/DRAIN/DONE. start outside IDLE is ignored.
//  Fetch: rd_en=1 in FETCH only when fifo_count + inflight < FIFO_D (inflight = issued but not yet written
//   to FIFO, max 2). rd_addr = ZZ_ORDER[n], n incremented per issued read.
//  Pipeline: cycle t rd_en -> t+1 capture rd_data, multiply -> t+2 registered result written to FIFO.
//   With out_ready=1 and start at edge 0: first out_valid in cycle 3, then one beat/cycle; done at cycle 67.
//  Arithmetic: p = coef * recip (signed x unsigned, COEF_W+RECIP_W+1 bits). r = (p + 2^15) >>> 16,
//   i.e. round half toward +inf. Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//   bypass=1: r = coef, then same saturation.
//  Handshake: out_data/out_idx/out_last held stable while out_valid & !out_ready. No beat is dropped or duplicated.
//   FIFO full never occurs due to credit rule; simultaneous push and pop in one cycle keep count unchanged.
//  out_idx = n of the beat; out_last = (out_idx == 63).
// STRUCTURE
//  dct_pkg: ZZ_ORDER[64] (6-bit), QTAB_RECIP[64] (RECIP_W, JPEG Annex K luminance, indexed by RAM addr),
//   COEF_W/OUT_W defaults, sat() function.
//  Sub-module dct_out_fifo: sync FIFO, FIFO_D x (OUT_W+7), push/pop/count, first-word-fall-through.
//  Top: FSM + read counter + credit logic + 2-stage quantize pipe.
// TESTING
//  1. RAM[a]=a, bypass=1, out_ready=1 -> out_data sequence 0,1,8,16,9,2,3,10,... (ZZ order); out_last on beat 64.
//  2. RAM[0]=1600, Q[0]=16 (recip 4096) -> beat 0 = 100; RAM coef -8 @Q16 -> 0; coef -9 @Q16 -> -1.
//  3. bypass=1, coef 32767 -> 2047; coef -32768 -> -2048 (OUT_W=12).
//  4. out_ready random 30% duty -> exactly 64 beats, idx 0..63 in order, data stable while stalled,
//     FIFO never overflows, rd_en never issued with count+inflight >= 4.
//  5. start pulsed again at cycle 20 -> ignored; single done at end; next start after done runs a new block.
//  6. rst_n low at beat 30 -> all outputs 0 immediately; no done; fresh start yields full 64 beats from idx 0.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared constants for the zig-zag quantizer: scan order, JPEG luminance reciprocals,
// default widths, FSM state type and the output saturation helper.
package dct_pkg;

    localparam int unsigned DCT_COEF_W  = 16;
    localparam int unsigned DCT_OUT_W   = 12;
    localparam int unsigned DCT_RECIP_W = 16;
    localparam int unsigned DCT_FIFO_D  = 4;

    // Wide enough for the signed coef x unsigned recip product plus rounding headroom
    localparam int unsigned SAT_W = 48;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } zz_state_t;

    localparam logic [5:0] ZZ_ORDER [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // round(65536/Q) for the Annex K luminance table, row-major by RAM address
    localparam logic [15:0] QTAB_RECIP [64] = '{
        16'd4096, 16'd5958, 16'd6554, 16'd4096, 16'd2731, 16'd1638, 16'd1285, 16'd1074,
        16'd5461, 16'd5461, 16'd4681, 16'd3449, 16'd2521, 16'd1130, 16'd1092, 16'd1192,
        16'd4681, 16'd5041, 16'd4096, 16'd2731, 16'd1638, 16'd1150, 16'd950,  16'd1170,
        16'd4681, 16'd3855, 16'd2979, 16'd2260, 16'd1285, 16'd753,  16'd819,  16'd1057,
        16'd3641, 16'd2979, 16'd1771, 16'd1170, 16'd964,  16'd601,  16'd636,  16'd851,
        16'd2731, 16'd1872, 16'd1192, 16'd1024, 16'd809,  16'd630,  16'd580,  16'd712,
        16'd1337, 16'd1024, 16'd840,  16'd753,  16'd636,  16'd542,  16'd546,  16'd649,
        16'd910,  16'd712,  16'd690,  16'd669,  16'd585,  16'd655,  16'd636,  16'd662
    };

    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] x,
                                                    input int unsigned out_w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (out_w - 1)) - SAT_W'(1);
        lo = ~hi;
        if (x > hi)      return hi;
        else if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/dct_out_fifo.sv
// First-word-fall-through synchronous FIFO carrying {last, idx, data} beats;
// rdata reads as zero while empty so downstream ports idle at 0.
module dct_out_fifo #(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == ($clog2(DEPTH) + 1)'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dct_zigzag_quantizer.sv
// Reads one 8x8 coefficient block in zig-zag order, quantizes each coefficient by
// reciprocal multiply with round-half-up and saturation, and streams beats out.
module dct_zigzag_quantizer
    import dct_pkg::*;
#(
    parameter int unsigned COEF_W  = DCT_COEF_W,
    parameter int unsigned OUT_W   = DCT_OUT_W,
    parameter int unsigned RECIP_W = DCT_RECIP_W,
    parameter int unsigned FIFO_D  = DCT_FIFO_D
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              bypass,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [5:0]        rd_addr,
    input  logic [COEF_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [5:0]        out_idx,
    output logic              out_last
);
    localparam int unsigned CNT_W = $clog2(FIFO_D) + 1;
    localparam int unsigned ENT_W = OUT_W + 7;
    localparam logic signed [SAT_W-1:0] HALF = SAT_W'(1) <<< (RECIP_W - 1);

    zz_state_t state, state_nx;

    logic [5:0]          rd_cnt;
    logic                bypass_q;
    logic                s1_valid;
    logic [5:0]          s1_idx;
    logic [RECIP_W-1:0]  s1_recip;
    logic                s2_valid;
    logic [5:0]          s2_idx;
    logic [OUT_W-1:0]    s2_data;

    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_empty;
    logic [ENT_W-1:0]    fifo_rdata;
    logic                pop;
    logic [CNT_W:0]      occupancy;
    logic                credit_ok;

    logic signed [SAT_W-1:0] coef_x;
    logic signed [SAT_W-1:0] recip_x;
    logic signed [SAT_W-1:0] prod;
    logic signed [SAT_W-1:0] rounded;
    logic signed [SAT_W-1:0] pre_sat;
    logic [OUT_W-1:0]        q_data;

    // Reads in the two pipe stages already own a FIFO slot, so the FIFO can never overflow
    assign occupancy = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(s1_valid) + (CNT_W + 1)'(s2_valid);
    assign credit_ok = occupancy < (CNT_W + 1)'(FIFO_D);

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign rd_addr   = rd_en ? ZZ_ORDER[rd_cnt] : '0;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_data  = fifo_rdata[OUT_W-1:0];
    assign out_idx   = fifo_rdata[OUT_W+5:OUT_W];
    assign out_last  = fifo_rdata[ENT_W-1];

    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_FETCH;
            ST_FETCH: begin
                rd_en = credit_ok;
                if (credit_ok && rd_cnt == 6'd63) state_nx = ST_DRAIN;
            end
            ST_DRAIN: if (pop && out_last) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // rd_data is valid in the cycle after rd_en, aligned with s1_recip
    always_comb begin
        coef_x  = SAT_W'($signed(rd_data));
        recip_x = SAT_W'(s1_recip);
        prod    = coef_x * recip_x;
        rounded = (prod + HALF) >>> RECIP_W;
        pre_sat = bypass_q ? coef_x : rounded;
        q_data  = OUT_W'(sat(pre_sat, OUT_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rd_cnt   <= '0;
            bypass_q <= 1'b0;
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_recip <= '0;
            s2_valid <= 1'b0;
            s2_idx   <= '0;
            s2_data  <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && start) begin
                rd_cnt   <= '0;
                bypass_q <= bypass;
            end else if (rd_en) begin
                rd_cnt <= rd_cnt + 6'd1;
            end
            s1_valid <= rd_en;
            s1_idx   <= rd_cnt;
            s1_recip <= RECIP_W'(QTAB_RECIP[rd_addr]);
            s2_valid <= s1_valid;
            s2_idx   <= s1_idx;
            s2_data  <= q_data;
        end
    end

    dct_out_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_D)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s2_valid),
        .wdata ({(s2_idx == 6'd63), s2_idx, s2_data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_dct_zigzag_quantizer.sv
// Directed bench for dct_zigzag_quantizer: zig-zag order, quantization, saturation,
// back-pressure, ignored restart and mid-block reset.
module tb_dct_zigzag_quantizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        bypass = 1'b0;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic [15:0] rd_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_data;
    logic [5:0]  out_idx;
    logic        out_last;

    logic [15:0] ram [64];
    int          exp_by_addr [64];

    int tests_run = 0;
    int tests_failed = 0;

    int   got_data [64];
    int   got_idx  [64];
    logic got_last [64];
    int   nbeats, done_cnt, stall_err, credit_err, first_valid, done_cyc;
    bit   timed_out, extra_beats, aborted;
    logic [28:0] snap;

    dct_zigzag_quantizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bypass    (bypass),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= ram[rd_addr];
    end

    // Independent zig-zag model: walk anti-diagonals, alternating direction
    function automatic int zz_addr(input int n);
        int k;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo;
            int hi;
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            for (int j = 0; j <= hi - lo; j++) begin
                int row;
                row = (s % 2 == 0) ? hi - j : lo + j;
                if (k == n) return row * 8 + (s - row);
                k++;
            end
        end
        return -1;
    endfunction

    task automatic clear_ram();
        for (int a = 0; a < 64; a++) begin
            ram[a] = '0;
            exp_by_addr[a] = 0;
        end
    endtask

    task automatic set_coef(input int a, input int coef, input int expv);
        ram[a] = 16'(coef);
        exp_by_addr[a] = expv;
    endtask

    // Runs one block and records what came out; comparisons live in the test tasks
    task automatic run_block(input int ready_pct, input int restart_at, input int abort_beat);
        int issued, post;
        logic held_v, held_l;
        logic [11:0] held_d;
        logic [5:0]  held_i;
        nbeats = 0; done_cnt = 0; stall_err = 0; credit_err = 0;
        first_valid = -1; done_cyc = -1; timed_out = 1; extra_beats = 0; aborted = 0;
        issued = 0; post = 0; held_v = 0; held_l = 0; held_d = '0; held_i = '0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start = (cyc == restart_at);
            out_ready = ($urandom_range(99) < ready_pct);
            if (abort_beat >= 0 && nbeats == abort_beat) begin
                rst_n = 1'b0;
                #1;
                snap = {busy, done, rd_en, rd_addr, out_valid, out_data, out_idx, out_last};
                aborted = 1; timed_out = 0;
                break;
            end
            #1;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (held_v && (!out_valid || out_data !== held_d || out_idx !== held_i || out_last !== held_l))
                stall_err++;
            held_v = out_valid && !out_ready;
            held_d = out_data; held_i = out_idx; held_l = out_last;
            if (rd_en) begin
                if (issued - nbeats >= 4) credit_err++;
                issued++;
            end
            if (out_valid && out_ready) begin
                if (nbeats < 64) begin
                    got_data[nbeats] = $signed(out_data);
                    got_idx[nbeats]  = int'(out_idx);
                    got_last[nbeats] = out_last;
                end else begin
                    extra_beats = 1;
                end
                nbeats++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cnt > 0) begin
                post++;
                if (post == 4) begin
                    timed_out = 0;
                    break;
                end
            end
        end
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests_run++; if (busy !== 1'b0)      begin tests_failed++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        tests_run++; if (done !== 1'b0)      begin tests_failed++; $display("FAIL reset_done: got %0b expected 0", done); end
        tests_run++; if (rd_en !== 1'b0)     begin tests_failed++; $display("FAIL reset_rd_en: got %0b expected 0", rd_en); end
        tests_run++; if (rd_addr !== 6'd0)   begin tests_failed++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        tests_run++; if (out_data !== 12'd0) begin tests_failed++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        tests_run++; if (out_idx !== 6'd0)   begin tests_failed++; $display("FAIL reset_out_idx: got %0d expected 0", out_idx); end
        tests_run++; if (out_last !== 1'b0)  begin tests_failed++; $display("FAIL reset_out_last: got %0b expected 0", out_last); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zigzag_bypass();
        for (int a = 0; a < 64; a++) ram[a] = 16'(a);
        bypass = 1'b1;
        run_block(100, -1, -1);
        tests_run++; if (timed_out)       begin tests_failed++; $display("FAIL zz_timeout: got 1 expected 0"); end
        tests_run++; if (nbeats != 64)    begin tests_failed++; $display("FAIL zz_beats: got %0d expected 64", nbeats); end
        tests_run++; if (first_valid != 3) begin tests_failed++; $display("FAIL zz_first_valid_cycle: got %0d expected 3", first_valid); end
        tests_run++; if (done_cyc != 67)  begin tests_failed++; $display("FAIL zz_done_cycle: got %0d expected 67", done_cyc); end
        tests_run++; if (done_cnt != 1)   begin tests_failed++; $display("FAIL zz_done_count: got %0d expected 1", done_cnt); end
        tests_run++; if (busy !== 1'b0)   begin tests_failed++; $display("FAIL zz_busy_after: got %0b expected 0", busy); end
        for (int n = 0; n < 64 && n < nbeats; n++) begin
            tests_run++;
            if (got_data[n] != zz_addr(n) || got_idx[n] != n || got_last[n] !== (n == 63)) begin
                tests_failed++;
                $display("FAIL zz_beat[%0d]: got data=%0d idx=%0d last=%0b expected data=%0d idx=%0d last=%0b",
                         n, got_data[n], got_idx[n], got_last[n], zz_addr(n), n, (n == 63));
            end
        end
    endtask

    task automatic test_quantize();
        clear_ram();
        set_coef(0, 1600, 100);
        set_coef(3, -8, 0);
        set_coef(18, -9, -1);
        set_coef(1, 100, 9);
        set_coef(63, -1000, -10);
        set_coef(2, 5, 1);
        set_coef(9, -6, 0);
        set_coef(10, 7, 0);
        set_coef(16, -32768, -2048);
        set_coef(24, 32767, 2047);
        bypass = 1'b0;
        run_block(100, -1, -1);
        tests_run++; if (nbeats != 64 || timed_out) begin tests_failed++; $display("FAIL q_beats: got %0d expected 64", nbeats); end
        for (int n = 0; n < 64 && n < nbeats; n++) begin
            tests_run++;
            if (got_data[n] != exp_by_addr[zz_addr(n)]) begin
                tests_failed++;
                $display("FAIL q_beat[%0d] addr %0d: got %0d expected %0d", n, zz_addr(n), got_data[n], exp_by_addr[zz_addr(n)]);
            end
        end
    endtask

    task automatic test_saturate_bypass();
        clear_ram();
        set_coef(0, 32767, 2047);
        set_coef(1, -32768, -2048);
        set_coef(8, 2047, 2047);
        set_coef(16, 2048, 2047);
        set_coef(9, -2048, -2048);
        set_coef(2, -2049, -2048);
        set_coef(3, -5, -5);
        bypass = 1'b1;
        run_block(100, -1, -1);
        tests_run++; if (nbeats != 64 || timed_out) begin tests_failed++; $display("FAIL sat_beats: got %0d expected 64", nbeats); end
        for (int n = 0; n < 7 && n < nbeats; n++) begin
            tests_run++;
            if (got_data[n] != exp_by_addr[zz_addr(n)]) begin
                tests_failed++;
                $display("FAIL sat_beat[%0d] addr %0d: got %0d expected %0d", n, zz_addr(n), got_data[n], exp_by_addr[zz_addr(n)]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_ram();
        for (int a = 0; a < 64; a++) set_coef(a, a * 37 - 1000, a * 37 - 1000);
        bypass = 1'b1;
        run_block(30, -1, -1);
        tests_run++; if (timed_out)      begin tests_failed++; $display("FAIL bp_timeout: got 1 expected 0"); end
        tests_run++; if (nbeats != 64 || extra_beats) begin tests_failed++; $display("FAIL bp_beats: got %0d expected 64", nbeats); end
        tests_run++; if (stall_err != 0) begin tests_failed++; $display("FAIL bp_stable_while_stalled: got %0d changes expected 0", stall_err); end
        tests_run++; if (credit_err != 0) begin tests_failed++; $display("FAIL bp_credit: got %0d over-issues expected 0", credit_err); end
        tests_run++; if (done_cnt != 1)  begin tests_failed++; $display("FAIL bp_done_count: got %0d expected 1", done_cnt); end
        for (int n = 0; n < 64 && n < nbeats; n++) begin
            tests_run++;
            if (got_idx[n] != n || got_data[n] != exp_by_addr[zz_addr(n)]) begin
                tests_failed++;
                $display("FAIL bp_beat[%0d]: got idx=%0d data=%0d expected idx=%0d data=%0d",
                         n, got_idx[n], got_data[n], n, exp_by_addr[zz_addr(n)]);
            end
        end
    endtask

    task automatic test_restart_ignored();
        for (int a = 0; a < 64; a++) ram[a] = 16'(a);
        bypass = 1'b1;
        run_block(100, 20, -1);
        tests_run++; if (nbeats != 64 || extra_beats) begin tests_failed++; $display("FAIL restart_beats: got %0d expected 64", nbeats); end
        tests_run++; if (done_cnt != 1)  begin tests_failed++; $display("FAIL restart_done_count: got %0d expected 1", done_cnt); end
        tests_run++; if (done_cyc != 67) begin tests_failed++; $display("FAIL restart_done_cycle: got %0d expected 67", done_cyc); end
        tests_run++; if (got_idx[63] != 63 || got_data[63] != 63) begin
            tests_failed++; $display("FAIL restart_last_beat: got idx=%0d data=%0d expected idx=63 data=63", got_idx[63], got_data[63]);
        end
        run_block(100, -1, -1);
        tests_run++; if (nbeats != 64 || timed_out) begin tests_failed++; $display("FAIL next_block_beats: got %0d expected 64", nbeats); end
        tests_run++; if (done_cnt != 1)  begin tests_failed++; $display("FAIL next_block_done: got %0d expected 1", done_cnt); end
        tests_run++; if (got_idx[0] != 0 || got_data[5] != 2) begin
            tests_failed++; $display("FAIL next_block_order: got idx0=%0d data5=%0d expected idx0=0 data5=2", got_idx[0], got_data[5]);
        end
    endtask

    task automatic test_abort();
        int done_seen;
        int valid_seen;
        for (int a = 0; a < 64; a++) ram[a] = 16'(a);
        bypass = 1'b1;
        run_block(100, -1, 30);
        tests_run++; if (!aborted)       begin tests_failed++; $display("FAIL abort_reached: got 0 expected 1"); end
        tests_run++; if (snap !== '0)    begin tests_failed++; $display("FAIL abort_outputs_zero: got %h expected 0", snap); end
        tests_run++; if (done_cnt != 0)  begin tests_failed++; $display("FAIL abort_no_done_before: got %0d expected 0", done_cnt); end
        done_seen = 0;
        valid_seen = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (done) done_seen++;
            if (out_valid || busy) valid_seen++;
        end
        tests_run++; if (done_seen != 0)  begin tests_failed++; $display("FAIL abort_no_done: got %0d expected 0", done_seen); end
        tests_run++; if (valid_seen != 0) begin tests_failed++; $display("FAIL abort_idle: got %0d active cycles expected 0", valid_seen); end
        rst_n = 1'b1;
        run_block(100, -1, -1);
        tests_run++; if (nbeats != 64 || timed_out) begin tests_failed++; $display("FAIL fresh_beats: got %0d expected 64", nbeats); end
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL fresh_done: got %0d expected 1", done_cnt); end
        for (int n = 0; n < 64 && n < nbeats; n++) begin
            tests_run++;
            if (got_idx[n] != n || got_data[n] != zz_addr(n)) begin
                tests_failed++;
                $display("FAIL fresh_beat[%0d]: got idx=%0d data=%0d expected idx=%0d data=%0d",
                         n, got_idx[n], got_data[n], n, zz_addr(n));
            end
        end
    endtask

    initial begin
        clear_ram();
        test_reset();
        test_zigzag_bypass();
        test_quantize();
        test_saturate_bypass();
        test_backpressure();
        test_restart_ignored();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
